// File: rtl/rv_branch_resolve_unit.sv
// rv_branch_resolve_unit
// Resolves RISC-V B-type branches. For each beat it works out the branch
// direction, the next PC and whether fetch mispredicted it. Results then travel
// through an elastic valid/ready pipeline that is LATENCY register stages deep.
//
// Parameters
//   XLEN     operand, PC and immediate width (32 or 64)
//   LATENCY  register stages from input accept to out_valid (1..4)
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   flush              kills every in-flight entry; no beat is accepted this cycle
//   in_valid/in_ready  input handshake; in_ready is combinational from out_ready
//   rs1, rs2           source operands
//   funct3             branch type
//   pc, imm            branch address and sign-extended B-immediate
//   pred_taken         fetch-stage direction prediction
//   out_valid/out_ready output handshake
//   taken, target      resolved direction and next PC
//   mispredict         redirect required
//   illegal            funct3 is not a branch encoding
//
// Optional build macro RV_BRU_PERF_CNT_EN adds two saturating 32-bit counters,
// perf_branches and perf_mispredicts, advanced on each output handshake.
module rv_branch_resolve_unit #(
  parameter int XLEN    = 32,
  parameter int LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            pred_taken,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic [XLEN-1:0] target,
  output logic            mispredict,
  output logic            illegal
`ifdef RV_BRU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
`endif
);

  // Returns {illegal, taken} for one branch encoding.
  function automatic logic [1:0] resolve_cond(input logic [2:0]      f3,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic                   tk;
    logic                   ill;
    a_s = a;
    b_s = b;
    tk  = 1'b0;
    ill = 1'b0;
    case (f3)
      3'b000:  tk = (a == b);
      3'b001:  tk = (a != b);
      3'b100:  tk = (a_s < b_s);
      3'b101:  tk = !(a_s < b_s);
      3'b110:  tk = (a < b);
      3'b111:  tk = !(a < b);
      default: ill = 1'b1;
    endcase
    return {ill, tk};
  endfunction

  // Next-PC adder; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] next_pc(input logic            tk,
                                              input logic [XLEN-1:0] pc_v,
                                              input logic [XLEN-1:0] imm_v);
    return tk ? (pc_v + imm_v) : (pc_v + XLEN'(4));
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Input-side resolution, captured by stage 0
  logic [1:0]      cond_c;
  logic            taken_c;
  logic            illegal_c;
  logic            mispredict_c;
  logic [XLEN-1:0] target_c;

  always_comb begin
    cond_c       = resolve_cond(funct3, rs1, rs2);
    illegal_c    = cond_c[1];
    taken_c      = cond_c[0];
    target_c     = next_pc(taken_c, pc, imm);
    // An illegal encoding is treated as not-taken, so the redirect follows the prediction.
    mispredict_c = illegal_c ? pred_taken : (taken_c ^ pred_taken);
  end

  logic [LATENCY-1:0]           vld_q,        vld_d;
  logic [LATENCY-1:0]           taken_q,      taken_d;
  logic [LATENCY-1:0]           mispredict_q, mispredict_d;
  logic [LATENCY-1:0]           illegal_q,    illegal_d;
  logic [LATENCY-1:0][XLEN-1:0] target_q,     target_d;
  logic [LATENCY-1:0]           adv;

  // Stage k advances when any stage from k to the tail is empty, or the
  // output is being accepted. Written in this flattened form so that adv
  // does not depend on itself.
  always_comb begin
    logic full_tail;
    adv = '0;
    for (int k = 0; k < LATENCY; k++) begin
      full_tail = 1'b1;
      for (int j = k; j < LATENCY; j++) full_tail &= vld_q[j];
      adv[k] = out_ready || !full_tail;
    end
  end

  assign in_ready = adv[0] && !flush;

  always_comb begin
    vld_d        = vld_q;
    taken_d      = taken_q;
    mispredict_d = mispredict_q;
    illegal_d    = illegal_q;
    target_d     = target_q;
    // Stage 0: capture a freshly resolved beat
    if (adv[0]) begin
      vld_d[0]        = in_valid && in_ready;
      taken_d[0]      = taken_c;
      mispredict_d[0] = mispredict_c;
      illegal_d[0]    = illegal_c;
      target_d[0]     = target_c;
    end
    // Stages 1..LATENCY-1: forward unchanged
    for (int k = 1; k < LATENCY; k++) begin
      if (adv[k]) begin
        vld_d[k]        = vld_q[k-1];
        taken_d[k]      = taken_q[k-1];
        mispredict_d[k] = mispredict_q[k-1];
        illegal_d[k]    = illegal_q[k-1];
        target_d[k]     = target_q[k-1];
      end
    end
    if (flush) vld_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q        <= '0;
      taken_q      <= '0;
      mispredict_q <= '0;
      illegal_q    <= '0;
      target_q     <= '0;
    end else begin
      vld_q        <= vld_d;
      taken_q      <= taken_d;
      mispredict_q <= mispredict_d;
      illegal_q    <= illegal_d;
      target_q     <= target_d;
    end
  end

  // Output stage
  assign out_valid  = vld_q[LATENCY-1];
  assign taken      = taken_q[LATENCY-1];
  assign target     = target_q[LATENCY-1];
  assign mispredict = mispredict_q[LATENCY-1];
  assign illegal    = illegal_q[LATENCY-1];

`ifdef RV_BRU_PERF_CNT_EN
  logic [31:0] perf_branches_q,    perf_branches_d;
  logic [31:0] perf_mispredicts_q, perf_mispredicts_d;

  always_comb begin
    perf_branches_d    = perf_branches_q;
    perf_mispredicts_d = perf_mispredicts_q;
    if (out_valid && out_ready) begin
      perf_branches_d = sat_inc(perf_branches_q);
      if (mispredict) perf_mispredicts_d = sat_inc(perf_mispredicts_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches_q    <= '0;
      perf_mispredicts_q <= '0;
    end else begin
      perf_branches_q    <= perf_branches_d;
      perf_mispredicts_q <= perf_mispredicts_d;
    end
  end

  assign perf_branches    = perf_branches_q;
  assign perf_mispredicts = perf_mispredicts_q;
`endif

endmodule

// File: tb/tb_rv_branch_resolve_unit.sv
// Bench for rv_branch_resolve_unit: one LATENCY=1 and one LATENCY=3 instance
// driven by independent streams of the same beat table. A scoreboard queue per
// instance holds the expected results of accepted beats.
module tb_rv_branch_resolve_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, out_ready;
  logic [1:0]       iv, ir, ov, tk, mp, il, pr;
  logic [1:0][31:0] r1, r2, pcv, imv, tg;
  logic [1:0][2:0]  f3;
`ifdef RV_BRU_PERF_CNT_EN
  logic [1:0][31:0] pb, pm;
`endif

  rv_branch_resolve_unit #(.XLEN(32), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv[0]), .in_ready(ir[0]),
    .rs1(r1[0]), .rs2(r2[0]), .funct3(f3[0]), .pc(pcv[0]), .imm(imv[0]),
    .pred_taken(pr[0]), .out_valid(ov[0]), .out_ready(out_ready), .taken(tk[0]),
    .target(tg[0]), .mispredict(mp[0]), .illegal(il[0])
`ifdef RV_BRU_PERF_CNT_EN
    , .perf_branches(pb[0]), .perf_mispredicts(pm[0])
`endif
  );

  rv_branch_resolve_unit #(.XLEN(32), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv[1]), .in_ready(ir[1]),
    .rs1(r1[1]), .rs2(r2[1]), .funct3(f3[1]), .pc(pcv[1]), .imm(imv[1]),
    .pred_taken(pr[1]), .out_valid(ov[1]), .out_ready(out_ready), .taken(tk[1]),
    .target(tg[1]), .mispredict(mp[1]), .illegal(il[1])
`ifdef RV_BRU_PERF_CNT_EN
    , .perf_branches(pb[1]), .perf_mispredicts(pm[1])
`endif
  );

  typedef struct {
    logic [31:0] r1, r2, pc, im;
    logic [2:0]  f3;
    logic        pr;
  } beat_t;

  typedef struct {
    logic        tk;
    logic [31:0] tg;
    logic        mp;
    logic        il;
    int          acc;
    bit          ex;
    bit          shown;
  } exp_t;

  beat_t bt[$];
  exp_t  sb0[$];
  exp_t  sb1[$];
  int    cyc, checks, errors;
  bit    ex_mode;
  bit    acc_f[2];
  int    nb[2];
  int    nm[2];

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic beat_t mk(input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] f, input logic [31:0] p,
                               input logic [31:0] i, input logic pt);
    beat_t x;
    x.r1 = a; x.r2 = b; x.f3 = f; x.pc = p; x.im = i; x.pr = pt;
    return x;
  endfunction

  // Reference model of the branch resolution
  function automatic exp_t model(input beat_t b);
    exp_t e;
    logic t, i;
    t = 1'b0;
    i = 1'b0;
    case (b.f3)
      3'b000:  t = (b.r1 == b.r2);
      3'b001:  t = (b.r1 != b.r2);
      3'b100:  t = ($signed(b.r1) < $signed(b.r2));
      3'b101:  t = ($signed(b.r1) >= $signed(b.r2));
      3'b110:  t = (b.r1 < b.r2);
      3'b111:  t = (b.r1 >= b.r2);
      default: i = 1'b1;
    endcase
    e.tk = t;
    e.il = i;
    e.tg = t ? (b.pc + b.im) : (b.pc + 32'd4);
    e.mp = i ? b.pr : (t ^ b.pr);
    e.acc = 0;
    e.ex = 1'b0;
    e.shown = 1'b0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic load(input int d, input beat_t b);
    r1[d] = b.r1; r2[d] = b.r2; f3[d] = b.f3; pcv[d] = b.pc; imv[d] = b.im; pr[d] = b.pr;
  endtask

  task automatic mon(input int d);
    exp_t  h;
    beat_t cur;
    int    n;
    acc_f[d] = 1'b0;
    if (rst) return;
    n = (d == 0) ? sb0.size() : sb1.size();
    if (n > 0) begin
      if (d == 0) h = sb0[0]; else h = sb1[0];
    end
    if (ov[d]) begin
      if (n == 0) begin
        chk($sformatf("spurious_out_d%0d", d), 64'(ov[d]), 64'd0);
      end else begin
        chk($sformatf("taken_d%0d_c%0d", d, cyc), 64'(tk[d]), 64'(h.tk));
        chk($sformatf("target_d%0d_c%0d", d, cyc), 64'(tg[d]), 64'(h.tg));
        chk($sformatf("mispredict_d%0d_c%0d", d, cyc), 64'(mp[d]), 64'(h.mp));
        chk($sformatf("illegal_d%0d_c%0d", d, cyc), 64'(il[d]), 64'(h.il));
        if (!h.shown && h.ex)
          chk($sformatf("latency_d%0d_c%0d", d, cyc), 64'(cyc - h.acc), 64'(lat(d)));
        h.shown = 1'b1;
        if (d == 0) sb0[0] = h; else sb1[0] = h;
        if (out_ready) begin
          if (d == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
          nb[d]++;
          if (h.mp) nm[d]++;
        end
      end
    end else if (n > 0 && h.ex && (cyc - h.acc) >= lat(d)) begin
      chk($sformatf("missing_out_d%0d_c%0d", d, cyc), 64'(ov[d]), 64'd1);
    end
    if (iv[d] && ir[d]) begin
      cur = mk(r1[d], r2[d], f3[d], pcv[d], imv[d], pr[d]);
      h = model(cur);
      h.acc = cyc;
      h.ex = ex_mode;
      if (d == 0) sb0.push_back(h); else sb1.push_back(h);
      acc_f[d] = 1'b1;
    end
  endtask

  // One clock: observe before the edge, apply reset/flush to the scoreboard after it.
  task automatic cycle();
    #1;
    mon(0);
    mon(1);
    @(posedge clk);
    cyc++;
    if (rst) begin
      sb0.delete(); sb1.delete();
      nb[0] = 0; nb[1] = 0; nm[0] = 0; nm[1] = 0;
    end else if (flush) begin
      sb0.delete(); sb1.delete();
    end
    #1;
  endtask

  task automatic chk_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_valid_d%0d", tag, d), 64'(ov[d]), 64'd0);
      chk($sformatf("%s_taken_d%0d", tag, d), 64'(tk[d]), 64'd0);
      chk($sformatf("%s_target_d%0d", tag, d), 64'(tg[d]), 64'd0);
      chk($sformatf("%s_mispredict_d%0d", tag, d), 64'(mp[d]), 64'd0);
      chk($sformatf("%s_illegal_d%0d", tag, d), 64'(il[d]), 64'd0);
`ifdef RV_BRU_PERF_CNT_EN
      chk($sformatf("%s_perf_br_d%0d", tag, d), 64'(pb[d]), 64'd0);
      chk($sformatf("%s_perf_mp_d%0d", tag, d), 64'(pm[d]), 64'd0);
`endif
    end
  endtask

  // Stream beats lo..hi into both instances; out_ready is low for k in [st_lo, st_hi).
  task automatic run(input int lo, input int hi, input int st_lo, input int st_hi, input bit ex);
    int  b[2];
    bit  done;
    b[0] = lo;
    b[1] = lo;
    done = 1'b0;
    ex_mode = ex;
    for (int k = 0; k < 300 && !done; k++) begin
      for (int d = 0; d < 2; d++) begin
        if (b[d] <= hi) begin
          iv[d] = 1'b1;
          load(d, bt[b[d]]);
        end else begin
          iv[d] = 1'b0;
        end
      end
      out_ready = !(k >= st_lo && k < st_hi);
      if (st_hi > st_lo && k == st_hi - 1) begin
        #1;
        chk("stall_in_ready_d0", 64'(ir[0]), 64'd0);
        chk("stall_in_ready_d1", 64'(ir[1]), 64'd0);
      end
      cycle();
      for (int d = 0; d < 2; d++) if (acc_f[d]) b[d]++;
      done = (b[0] > hi) && (b[1] > hi) && (sb0.size() == 0) && (sb1.size() == 0);
    end
    iv = '0;
    out_ready = 1'b1;
    chk($sformatf("stream_%0d_%0d_completes", lo, hi), 64'(done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; ex_mode = 1'b0;
    nb[0] = 0; nb[1] = 0; nm[0] = 0; nm[1] = 0;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1; iv = '0;
    r1 = '0; r2 = '0; f3 = '0; pcv = '0; imv = '0; pr = '0;

    // Beat table: 0 single eq beat, 1..8 directed stream, 9..26 random, 27..31 perf set
    bt.push_back(mk(32'd5, 32'd5, 3'b000, 32'h100, 32'h20, 1'b0));
    bt.push_back(mk(32'hFFFF_FFFF, 32'd1, 3'b100, 32'h200, 32'h40, 1'b0));
    bt.push_back(mk(32'hFFFF_FFFF, 32'd1, 3'b110, 32'h200, 32'h40, 1'b1));
    bt.push_back(mk(32'd1, 32'd2, 3'b010, 32'h300, 32'h10, 1'b1));
    bt.push_back(mk(32'd1, 32'd2, 3'b011, 32'h300, 32'h10, 1'b0));
    bt.push_back(mk(32'd3, 32'd3, 3'b000, 32'hFFFF_FFFC, 32'd8, 1'b1));
    bt.push_back(mk(32'd3, 32'd4, 3'b000, 32'hFFFF_FFFF, 32'd8, 1'b0));
    bt.push_back(mk(32'd7, 32'd3, 3'b101, 32'h400, 32'hFFFF_FFF0, 1'b1));
    bt.push_back(mk(32'h8000_0000, 32'd1, 3'b111, 32'h500, 32'h8, 1'b0));
    for (int i = 9; i < 27; i++) begin
      beat_t x;
      x.r1 = $urandom;
      x.r2 = ($urandom_range(0, 3) == 0) ? x.r1 : $urandom;
      x.f3 = 3'($urandom_range(0, 7));
      x.pc = $urandom;
      x.im = $urandom;
      x.pr = 1'($urandom_range(0, 1));
      bt.push_back(x);
    end
    bt.push_back(bt[4]);
    bt.push_back(bt[5]);
    bt.push_back(bt[7]);
    bt.push_back(bt[1]);
    bt.push_back(bt[2]);

    // Reset state
    cycle();
    cycle();
    chk_zero("reset");
    rst = 1'b0;
    #1;
    chk("in_ready_after_reset_d0", 64'(ir[0]), 64'd1);
    chk("in_ready_after_reset_d1", 64'(ir[1]), 64'd1);

    // Single eq beat, then the directed 8-beat stream at full throughput
    run(0, 0, 0, 0, 1'b1);
    run(1, 8, 0, 0, 1'b1);

    // Random stream with a 4-cycle output stall
    run(9, 20, 4, 8, 1'b0);

    // Flush with two beats in flight and a third offered in the flush cycle
    ex_mode = 1'b0;
    out_ready = 1'b1;
    iv = 2'b11; load(0, bt[21]); load(1, bt[21]);
    cycle();
    load(0, bt[22]); load(1, bt[22]);
    cycle();
    flush = 1'b1;
    load(0, bt[23]); load(1, bt[23]);
    #1;
    chk("flush_in_ready_d0", 64'(ir[0]), 64'd0);
    chk("flush_in_ready_d1", 64'(ir[1]), 64'd0);
    cycle();
    flush = 1'b0;
    iv = '0;
    chk("post_flush_valid_d0", 64'(ov[0]), 64'd0);
    chk("post_flush_valid_d1", 64'(ov[1]), 64'd0);
    run(24, 24, 0, 0, 1'b1);

    // Reset with entries in flight
    iv = 2'b11; load(0, bt[25]); load(1, bt[25]);
    cycle();
    load(0, bt[26]); load(1, bt[26]);
    cycle();
    rst = 1'b1;
    iv = '0;
    cycle();
    chk_zero("midrst");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // Five handshakes, two of them mispredicts
    run(27, 31, 0, 0, 1'b1);
`ifdef RV_BRU_PERF_CNT_EN
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("perf_br_d%0d", d), 64'(pb[d]), 64'd5);
      chk($sformatf("perf_mp_d%0d", d), 64'(pm[d]), 64'd2);
      chk($sformatf("perf_br_model_d%0d", d), 64'(pb[d]), 64'(nb[d]));
      chk($sformatf("perf_mp_model_d%0d", d), 64'(pm[d]), 64'(nm[d]));
    end
`endif
    for (int i = 0; i < 3; i++) cycle();
    chk("idle_valid_d0", 64'(ov[0]), 64'd0);
    chk("idle_valid_d1", 64'(ov[1]), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
